// File: rtl/dsp_pkg.sv
// Shared definitions for the dsp req/resp port and the sequential 32x32 multiplier
// that drives it.
package dsp_pkg;

  localparam logic [31:0] DSP_CMD_MUL24   = 32'd0;
  localparam logic [31:0] DSP_CMD_MUL16X2 = 32'd2;

  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_MUL,
    SEQ_CORR,
    SEQ_DONE
  } seq_state_t;

  typedef logic [1:0] seq_step_t;

  localparam seq_step_t STEP_LAST = 2'd3;

endpackage

// File: rtl/dsp_mul32_seq.sv
// 32x32 multiply initiator: splits each job into four 16x16 partials on the dsp port,
// accumulates them into 64 bits and applies a two's-complement fix-up for signed jobs.
module dsp_mul32_seq
  import dsp_pkg::*;
#(
  parameter logic [31:0] CMD_MUL24 = DSP_CMD_MUL24,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [31:0] req_command,
  output logic [31:0] req_in_1,
  output logic [31:0] req_in_2,
  input  logic [63:0] resp_result
);

  seq_state_t  state;
  seq_step_t   step;
  logic [63:0] acc;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic        sgn;

  // Only the low word of the dsp result is meaningful for 16x16 partials.
  logic [31:0] partial;
  logic        unused_resp_hi;

  assign partial        = resp_result[31:0];
  assign unused_resp_hi = ^resp_result[63:32];
  assign req_command    = CMD_MUL24;

  // Weight a partial by its position: lo*lo at 0, the cross terms at 16, hi*hi at 32.
  function automatic logic [63:0] align_partial(input seq_step_t s, input logic [31:0] p);
    logic [63:0] r;
    case (s)
      2'd0:    r = {32'h0, p};
      2'd1,
      2'd2:    r = {16'h0, p, 16'h0};
      default: r = {p, 32'h0};
    endcase
    return r;
  endfunction

  // Unsigned product minus this term equals the signed product modulo 2^64.
  function automatic logic [63:0] sign_corr(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ca;
    logic [63:0] cb;
    ca = a[31] ? {b, 32'h0} : 64'h0;
    cb = b[31] ? {a, 32'h0} : 64'h0;
    return ca + cb;
  endfunction

  // Operand halves come from the latched job only; step[0] picks a's half, step[1] picks b's.
  always_comb begin
    req_in_1 = 32'h0;
    req_in_2 = 32'h0;
    if (state == SEQ_MUL) begin
      req_in_1 = {16'h0, step[0] ? a_r[31:HALF_W] : a_r[HALF_W-1:0]};
      req_in_2 = {16'h0, step[1] ? b_r[31:HALF_W] : b_r[HALF_W-1:0]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SEQ_IDLE;
      step       <= 2'd0;
      acc        <= 64'h0;
      a_r        <= 32'h0;
      b_r        <= 32'h0;
      sgn        <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= 64'h0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            sgn      <= in_signed & SIGNED_EN;
            acc      <= 64'h0;
            step     <= 2'd0;
            in_ready <= 1'b0;
            state    <= SEQ_MUL;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SEQ_MUL: begin
          acc  <= acc + align_partial(step, partial);
          step <= step + 2'd1;
          if (step == STEP_LAST) begin
            state <= SEQ_CORR;
          end
        end
        SEQ_CORR: begin
          out_result <= sgn ? (acc - sign_corr(a_r, b_r)) : acc;
          acc        <= sgn ? (acc - sign_corr(a_r, b_r)) : acc;
          out_valid  <= 1'b1;
          state      <= SEQ_DONE;
        end
        SEQ_DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= SEQ_IDLE;
          end
        end
        default: begin
          state <= SEQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mul32_seq.sv
// Bench for dsp_mul32_seq with a behavioural dsp model on the req/resp port, a cycle-level
// reference model with a per-cycle compare, and directed jobs with literal expectations.
module tb_dsp_mul32_seq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [31:0] req_command;
  logic [31:0] req_in_1;
  logic [31:0] req_in_2;
  logic [63:0] resp_result;

  int checks;
  int failures;

  dsp_mul32_seq dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .req_command (req_command),
    .req_in_1    (req_in_1),
    .req_in_2    (req_in_2),
    .resp_result (resp_result)
  );

  // Combinational dsp: 24x24 unsigned for command 0, garbage in the don't-care upper word.
  logic [47:0] dsp_prod;
  assign dsp_prod    = {24'h0, req_in_1[23:0]} * {24'h0, req_in_2[23:0]};
  assign resp_result = (req_command == 32'd0) ? {16'hDEAD, dsp_prod} : 64'hDEADBEEF_DEADBEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic        [63:0] ua;
    logic        [63:0] ub;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'h0, a};
    ub = {32'h0, b};
    return s ? 64'(sa * sb) : (ua * ub);
  endfunction

  // Reference model: accept when ready, result 5 edges later, hold until out_ready.
  logic        m_ready;
  logic        m_valid;
  int          m_cnt;
  logic [63:0] m_result;
  logic [63:0] m_pending;
  logic [31:0] m_a;
  logic [31:0] m_b;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ready   <= 1'b0;
      m_valid   <= 1'b0;
      m_cnt     <= 0;
      m_result  <= 64'h0;
      m_pending <= 64'h0;
      m_a       <= 32'h0;
      m_b       <= 32'h0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_valid  <= 1'b1;
        m_result <= m_pending;
      end
    end else if (m_ready && in_valid) begin
      m_ready   <= 1'b0;
      m_cnt     <= 5;
      m_a       <= in_a;
      m_b       <= in_b;
      m_pending <= golden(in_a, in_b, in_signed);
    end else begin
      m_ready <= 1'b1;
    end
  end

  // Per-cycle compare; the four partial-product cycles correspond to m_cnt 5,4,3,2.
  always @(negedge clk) begin
    logic [31:0] e1;
    logic [31:0] e2;
    e1 = 32'h0;
    e2 = 32'h0;
    case (m_cnt)
      5: begin e1 = {16'h0, m_a[15:0]};  e2 = {16'h0, m_b[15:0]};  end
      4: begin e1 = {16'h0, m_a[31:16]}; e2 = {16'h0, m_b[15:0]};  end
      3: begin e1 = {16'h0, m_a[15:0]};  e2 = {16'h0, m_b[31:16]}; end
      2: begin e1 = {16'h0, m_a[31:16]}; e2 = {16'h0, m_b[31:16]}; end
      default: ;
    endcase
    chk("cyc_in_ready", {63'h0, in_ready}, {63'h0, m_ready});
    chk("cyc_out_valid", {63'h0, out_valid}, {63'h0, m_valid});
    if (m_valid) chk("cyc_out_result", out_result, m_result);
    chk("cyc_req_command", {32'h0, req_command}, 64'h0);
    chk("cyc_req_in_1", {32'h0, req_in_1}, {32'h0, e1});
    chk("cyc_req_in_2", {32'h0, req_in_2}, {32'h0, e2});
  end

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, output logic [63:0] res, output int edges,
                         output logic [3:0][31:0] r1, output logic [3:0][31:0] r2);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", {63'h0, in_ready}, 64'h1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    @(posedge clk);
    @(negedge clk);
    // Keep requesting with different operands while busy; these must be ignored.
    in_a      = ~a;
    in_b      = a ^ b;
    in_signed = ~s;
    edges = 0;
    r1 = '0;
    r2 = '0;
    while (!out_valid && edges < 20) begin
      if (edges < 4) begin
        r1[edges] = req_in_1;
        r2[edges] = req_in_2;
      end
      @(negedge clk);
      edges++;
    end
    if (!out_valid) chk("result_timeout", {63'h0, out_valid}, 64'h1);
    in_valid = 1'b0;
    res = out_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {63'h0, out_valid}, 64'h1);
      chk("hold_out_result", out_result, res);
      chk("hold_in_ready", {63'h0, in_ready}, 64'h0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_hs_in_ready", {63'h0, in_ready}, 64'h1);
    chk("post_hs_out_valid", {63'h0, out_valid}, 64'h0);
  endtask

  logic [63:0]       res;
  int                edges;
  logic [3:0][31:0]  r1;
  logic [3:0][31:0]  r2;

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    in_signed = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_out_result", out_result, 64'h0);
    chk("rst_req_in_1", {32'h0, req_in_1}, 64'h0);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("first_in_ready", {63'h0, in_ready}, 64'h1);

    // Unsigned all-ones, latency of exactly five edges.
    run_job(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, res, edges, r1, r2);
    chk("t1_result", res, 64'hFFFFFFFE00000001);
    chk("t1_latency", 64'(edges), 64'd5);

    // -1 * -1 signed, then the same operands unsigned.
    run_job(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, res, edges, r1, r2);
    chk("t2_signed", res, 64'h0000000000000001);
    run_job(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, res, edges, r1, r2);
    chk("t2_unsigned", res, 64'hFFFFFFFE00000001);

    run_job(32'h80000000, 32'h7FFFFFFF, 1'b1, 0, res, edges, r1, r2);
    chk("t3_result", res, 64'hC000000080000000);

    // Mixed-sign signed job and a small unsigned job.
    run_job(32'hFFFFFFFE, 32'h00000003, 1'b1, 0, res, edges, r1, r2);
    chk("t3b_neg6", res, 64'hFFFFFFFFFFFFFFFA);
    run_job(32'h00000007, 32'h00000006, 1'b0, 0, res, edges, r1, r2);
    chk("t3c_small", res, 64'd42);

    // Partial-product operand sequence.
    run_job(32'h12345678, 32'h9ABCDEF0, 1'b0, 0, res, edges, r1, r2);
    chk("t4_result", res, 64'h0B00EA4E242D2080);
    chk("t4_s0_in1", {32'h0, r1[0]}, 64'h5678);
    chk("t4_s0_in2", {32'h0, r2[0]}, 64'hDEF0);
    chk("t4_s1_in1", {32'h0, r1[1]}, 64'h1234);
    chk("t4_s1_in2", {32'h0, r2[1]}, 64'hDEF0);
    chk("t4_s2_in1", {32'h0, r1[2]}, 64'h5678);
    chk("t4_s2_in2", {32'h0, r2[2]}, 64'h9ABC);
    chk("t4_s3_in1", {32'h0, r1[3]}, 64'h1234);
    chk("t4_s3_in2", {32'h0, r2[3]}, 64'h9ABC);

    // Back-pressure: result held for three cycles with out_ready low.
    run_job(32'h12345678, 32'h9ABCDEF0, 1'b0, 3, res, edges, r1, r2);
    chk("t5_result", res, 64'h0B00EA4E242D2080);

    // Reset pulsed while the third partial is on the port.
    in_valid  = 1'b1;
    in_a      = 32'hAAAA5555;
    in_b      = 32'h3333CCCC;
    in_signed = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_pre_req_in_1", {32'h0, req_in_1}, 64'h5555);
    chk("t6_pre_req_in_2", {32'h0, req_in_2}, 64'h3333);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_req_in_1", {32'h0, req_in_1}, 64'h0);
    chk("t6_rst_req_in_2", {32'h0, req_in_2}, 64'h0);
    chk("t6_rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("t6_rst_in_ready", {63'h0, in_ready}, 64'h0);
    chk("t6_rst_out_result", out_result, 64'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    run_job(32'h12345678, 32'h9ABCDEF0, 1'b0, 0, res, edges, r1, r2);
    chk("t6_after_result", res, 64'h0B00EA4E242D2080);
    chk("t6_after_latency", 64'(edges), 64'd5);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
